// File: rtl/result_unloader.sv
// Streams the 25-element result matrix out of MemoryBlock over valid/ready
// and assembles a packed copy of the whole matrix.
module result_unloader #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 16,
  parameter int ELEM_W    = 8,
  parameter int N_ELEM    = 25,
  parameter int BASE_ADDR = 1,
  parameter int READ_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_we,
  input  logic [DATA_W-1:0]          mem_q,
  output logic signed [ELEM_W-1:0]   elem_data,
  output logic [4:0]                 elem_index,
  output logic                       elem_valid,
  input  logic                       elem_ready,
  output logic [N_ELEM*ELEM_W-1:0]   result_matrix,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    DONE
  } state_t;

  localparam int CW = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(READ_LAT - 1);
  localparam logic [4:0] LAST_K = 5'(N_ELEM - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t        state;
  logic [4:0]    k;
  logic [CW-1:0] cnt;

  // The high byte of each word carries nothing for the result stream.
  logic unused_hi;
  assign unused_hi = ^mem_q[DATA_W-1:ELEM_W];

  assign mem_we = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      cnt           <= '0;
      mem_addr      <= '0;
      elem_data     <= '0;
      elem_index    <= '0;
      elem_valid    <= 1'b0;
      result_matrix <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            k             <= '0;
            result_matrix <= '0;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          mem_addr <= BASE + ADDR_W'(k);
          cnt      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == LAST_CNT) begin
            elem_data  <= mem_q[ELEM_W-1:0];
            elem_index <= k;
            elem_valid <= 1'b1;
            for (int i = 0; i < N_ELEM; i++) begin
              if (k == 5'(i))
                result_matrix[i*ELEM_W +: ELEM_W] <= mem_q[ELEM_W-1:0];
            end
            state <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (elem_ready) begin
            elem_valid <= 1'b0;
            if (k == LAST_K) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              k     <= k + 5'd1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: memory model, directed scenarios with
// randomized data/backpressure against a queue-free reference model.
module tb_result_unloader;

  localparam int BASE = 1;
  localparam int RL   = 2;
  localparam int N    = 25;

  logic               clk;
  logic               rst;
  logic               start;
  logic [6:0]         mem_addr;
  logic               mem_we;
  logic [15:0]        mem_q;
  logic signed [7:0]  elem_data;
  logic [4:0]         elem_index;
  logic               elem_valid;
  logic               elem_ready;
  logic [199:0]       result_matrix;
  logic               busy;
  logic               done;

  logic [15:0]        mem [0:127];
  logic signed [7:0]  got [N];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 dcyc;
  logic [199:0]       em;

  result_unloader dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_q(mem_q),
    .elem_data(elem_data),
    .elem_index(elem_index),
    .elem_valid(elem_valid),
    .elem_ready(elem_ready),
    .result_matrix(result_matrix),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-to-q latency of RL cycles as seen by the unloader's sampling.
  always @(posedge clk) mem_q <= mem[mem_addr];

  task automatic check(input string tag, input logic [199:0] obs,
                       input logic [199:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, elem_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_data"}, $unsigned(elem_data), 8'h00);
    check({tag, "_index"}, elem_index, 5'd0);
    check({tag, "_addr"}, mem_addr, 7'd0);
    check({tag, "_matrix"}, result_matrix, 200'd0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
  endtask

  task automatic unload(input int rdy_pct, input int stall_k,
                        input int pulse_k, input int abort_k,
                        output int done_cyc, output logic [199:0] expm);
    logic [7:0] exp [N];
    int nxt, cyc, last_x, stall_n;
    bit seen, fin;
    expm = '0;
    for (int i = 0; i < N; i++) begin
      exp[i] = mem[BASE + i][7:0];
      expm[i*8 +: 8] = exp[i];
    end
    nxt = 0; last_x = -1; stall_n = 0; seen = 0; fin = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    elem_ready = 1'b0;
    cyc = -1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      check("we", mem_we, 1'b0);
      if (cyc == 0) check("clear", result_matrix, 200'd0);
      if (cyc == 1) check("addr0", mem_addr, 7'(BASE));
      if (cyc >= 1)
        check("addr_rng", (mem_addr >= BASE && mem_addr < BASE + N), 1'b1);
      if (done) begin
        done_cyc = cyc;
        check("done_t", cyc, last_x + 1);
        check("done_n", nxt, N);
        @(negedge clk);
        check("busy_off", busy, 1'b0);
        check("done_once", done, 1'b0);
        check("matrix", result_matrix, expm);
        fin = 1;
      end else begin
        check("busy", busy, 1'b1);
        if (elem_valid) begin
          if (!seen) begin
            check("rise", cyc, last_x + RL + 2);
            seen = 1;
            if (nxt == pulse_k) start = 1'b1;
            if (nxt == abort_k) begin
              rst = 1'b1;
              start = 1'b1;
              elem_ready = 1'b0;
              @(negedge clk);
              check_zero("abort");
              rst = 1'b0;
              start = 1'b0;
              @(negedge clk);
              check("abort_idle", busy, 1'b0);
              return;
            end
          end
          check("idx", elem_index, nxt);
          check("data", $unsigned(elem_data), exp[nxt]);
          if (nxt == stall_k && stall_n < 5) begin
            elem_ready = 1'b0;
            stall_n++;
          end else begin
            elem_ready = ($urandom_range(99) < rdy_pct);
          end
          if (elem_ready) begin
            got[nxt] = elem_data;
            last_x = cyc;
            nxt++;
            seen = 0;
          end
        end else begin
          elem_ready = 1'($urandom_range(1));
        end
      end
    end
    check("timeout", fin, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    elem_ready = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < N; i++) mem[BASE + i] = 16'(2 * (i + 1));
    unload(100, -1, -1, -1, dcyc, em);
    check("t1_total", dcyc, 100);
    check("t1_last", $unsigned(got[N-1]), 8'd50);
    repeat (4) @(negedge clk);
    check("hold_matrix", result_matrix, em);

    unload(100, 3, -1, -1, dcyc, em);
    unload(60, 3, -1, -1, dcyc, em);

    fill_random();
    mem[BASE]     = 16'hAB80;
    mem[BASE + 1] = 16'h00F6;
    unload(70, -1, -1, -1, dcyc, em);
    check("neg128", int'(got[0]), -128);
    check("neg10", int'(got[1]), -10);
    check("m_lo", result_matrix[7:0], 8'h80);
    check("m_hi", result_matrix[15:8], 8'hF6);

    fill_random();
    unload(80, -1, -1, 10, dcyc, em);
    unload(100, -1, -1, -1, dcyc, em);
    check("restart_total", dcyc, 100);

    fill_random();
    unload(75, -1, 12, -1, dcyc, em);

    for (int r = 0; r < 2; r++) begin
      fill_random();
      unload(int'($urandom_range(90, 40)), -1, -1, -1, dcyc, em);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
